// File: rtl/gpio_reg_pkg.sv
// Shared constants, field layout and FSM encoding for the GPIO register writer.
package gpio_reg_pkg;

  // Register file geometry (fixed for this release).
  localparam int unsigned NUM_BANKS     = 4;
  localparam int unsigned REGS_PER_BANK = 8;
  localparam int unsigned REG_W         = 16;

  // GPIO word width and command/readback field layout.
  localparam int unsigned GPIO_W   = 32;
  localparam int unsigned STB_BIT  = 31;
  localparam int unsigned BANK_MSB = 30;
  localparam int unsigned BANK_LSB = 29;
  localparam int unsigned IDX_MSB  = 28;
  localparam int unsigned IDX_LSB  = 26;
  localparam int unsigned RSV_MSB  = 25;
  localparam int unsigned RSV_LSB  = 16;
  localparam int unsigned DATA_MSB = 15;
  localparam int unsigned DATA_LSB = 0;

  localparam int unsigned BANK_W = BANK_MSB - BANK_LSB + 1;
  localparam int unsigned IDX_W  = IDX_MSB - IDX_LSB + 1;
  localparam int unsigned RSV_W  = RSV_MSB - RSV_LSB + 1;
  localparam int unsigned DATA_W = DATA_MSB - DATA_LSB + 1;

  // Write sequencer states.
  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StWrite   = 2'b01,
    StWaitLow = 2'b10
  } state_e;

  // Assemble one per-bank readback word.
  function automatic logic [GPIO_W-1:0] readback_word(input logic              ack,
                                                      input logic [BANK_W-1:0] bank,
                                                      input logic [IDX_W-1:0]  idx,
                                                      input logic [DATA_W-1:0] data);
    return {ack, bank, idx, {RSV_W{1'b0}}, data};
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Two-flop synchronizer with synchronous active-high reset.
module gpio_sync
  import gpio_reg_pkg::*;
#(
  parameter int unsigned Width = GPIO_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] stage1_q;
  logic [Width-1:0] stage2_q;

  // Shift the asynchronous input through two flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stage1_q <= '0;
      stage2_q <= '0;
    end else begin
      stage1_q <= d_i;
      stage2_q <= stage1_q;
    end
  end

  assign q_o = stage2_q;

endmodule

// File: rtl/gpio_reg_writer.sv
// Decodes a PS command word arriving on a GPIO into writes of a banked register
// file, with a registered per-bank readback word and a toggling ack bit.
module gpio_reg_writer #(
  parameter int unsigned NUM_BANKS     = gpio_reg_pkg::NUM_BANKS,
  parameter int unsigned REGS_PER_BANK = gpio_reg_pkg::REGS_PER_BANK,
  parameter int unsigned REG_W         = gpio_reg_pkg::REG_W
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic [31:0]                             gpio1_i,
  output logic [31:0]                             gpio2_0_o,
  output logic [31:0]                             gpio2_1_o,
  output logic [31:0]                             gpio2_2_o,
  output logic [31:0]                             gpio2_3_o,
  output logic [NUM_BANKS*REGS_PER_BANK*REG_W-1:0] regs_o,
  output logic [NUM_BANKS-1:0]                    wr_stb_o
);

  localparam int unsigned BankW = gpio_reg_pkg::BANK_W;
  localparam int unsigned IdxW  = gpio_reg_pkg::IDX_W;

  // Synchronized command word; all decoding uses this stage.
  logic [31:0] sync2;

  gpio_sync #(
    .Width(32)
  ) u_sync (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .d_i  (gpio1_i),
    .q_o  (sync2)
  );

  logic             stb_s;
  logic [BankW-1:0] bank_s;
  logic [IdxW-1:0]  idx_s;
  logic [REG_W-1:0] data_s;
  logic             unused_rsv;

  assign stb_s      = sync2[gpio_reg_pkg::STB_BIT];
  assign bank_s     = sync2[gpio_reg_pkg::BANK_MSB:gpio_reg_pkg::BANK_LSB];
  assign idx_s      = sync2[gpio_reg_pkg::IDX_MSB:gpio_reg_pkg::IDX_LSB];
  assign data_s     = sync2[gpio_reg_pkg::DATA_MSB:gpio_reg_pkg::DATA_LSB];
  assign unused_rsv = ^sync2[gpio_reg_pkg::RSV_MSB:gpio_reg_pkg::RSV_LSB];

  // Edge detection. After reset the synchronizer and the previous-sample flop
  // refill from zero, which would fake a rising edge if the strobe was left
  // high; edges are therefore ignored until the previous-sample flop holds a
  // real post-reset sample.
  logic       stb_prev_q;
  logic [1:0] settle_q, settle_d;
  logic       settled;
  logic       stb_rise;

  assign settled  = (settle_q == 2'd3);
  assign settle_d = settled ? settle_q : settle_q + 2'd1;
  assign stb_rise = settled & stb_s & ~stb_prev_q;

  // Previous strobe sample and post-reset settle counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stb_prev_q <= 1'b0;
      settle_q   <= 2'd0;
    end else begin
      stb_prev_q <= stb_s;
      settle_q   <= settle_d;
    end
  end

  // Write sequencer state and latched command fields.
  gpio_reg_pkg::state_e state_q, state_d;
  logic [BankW-1:0]     bank_q, bank_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [REG_W-1:0]     data_q, data_d;
  logic                 do_write;

  // Next-state logic: capture on a strobe edge, write once, then wait for release.
  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    idx_d    = idx_q;
    data_d   = data_q;
    do_write = 1'b0;
    unique case (state_q)
      gpio_reg_pkg::StIdle: begin
        if (stb_rise) begin
          bank_d  = bank_s;
          idx_d   = idx_s;
          data_d  = data_s;
          state_d = gpio_reg_pkg::StWrite;
        end
      end
      gpio_reg_pkg::StWrite: begin
        // Committed once here; a strobe drop no longer matters.
        do_write = 1'b1;
        state_d  = gpio_reg_pkg::StWaitLow;
      end
      gpio_reg_pkg::StWaitLow: begin
        if (!stb_s) begin
          state_d = gpio_reg_pkg::StIdle;
        end
      end
      default: state_d = gpio_reg_pkg::StIdle;
    endcase
  end

  // FSM state and captured fields.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= gpio_reg_pkg::StIdle;
      bank_q  <= '0;
      idx_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      bank_q  <= bank_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  // Write strobe, ack toggle and register array.
  logic [NUM_BANKS-1:0] wr_stb_q, wr_stb_d;
  logic                 ack_q;
  logic [REG_W-1:0]     regs_q [NUM_BANKS][REGS_PER_BANK];

  // One-hot strobe for the bank being written this cycle.
  always_comb begin
    wr_stb_d = '0;
    if (do_write) begin
      wr_stb_d[bank_q] = 1'b1;
    end
  end

  // Strobe pulse and ack toggle, updated on the write edge.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_stb_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      wr_stb_q <= wr_stb_d;
      ack_q    <= ack_q ^ do_write;
    end
  end

  // Register file: only the latched address changes on a write.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        for (int r = 0; r < REGS_PER_BANK; r++) begin
          regs_q[b][r] <= '0;
        end
      end
    end else if (do_write) begin
      regs_q[bank_q][idx_q] <= data_q;
    end
  end

  // Per-bank readback words addressed by the synchronized index.
  logic [31:0] rb_q [NUM_BANKS];

  // Registered readback, one cycle behind the synchronized index.
  always_ff @(posedge clk_i) begin
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (rst_i) begin
        rb_q[k] <= gpio_reg_pkg::readback_word(1'b0, BankW'(k), '0, '0);
      end else begin
        rb_q[k] <= gpio_reg_pkg::readback_word(ack_q, BankW'(k), idx_s, regs_q[k][idx_s]);
      end
    end
  end

  assign gpio2_0_o = rb_q[0];
  assign gpio2_1_o = rb_q[1];
  assign gpio2_2_o = rb_q[2];
  assign gpio2_3_o = rb_q[3];
  assign wr_stb_o  = wr_stb_q;

  // Flatten the register array straight from the flops.
  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    for (genvar r = 0; r < REGS_PER_BANK; r++) begin : g_reg
      assign regs_o[(b*REGS_PER_BANK+r)*REG_W +: REG_W] = regs_q[b][r];
    end
  end

endmodule

// File: tb/tb_gpio_reg_writer.sv
// Directed self-checking bench for gpio_reg_writer.
module tb_gpio_reg_writer;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  gpio1_i;
  logic [31:0]  gpio2_0_o, gpio2_1_o, gpio2_2_o, gpio2_3_o;
  logic [511:0] regs_o;
  logic [3:0]   wr_stb_o;

  int tests = 0;
  int fails = 0;

  logic [15:0] model [4][8];
  logic        ack_m;
  int          pulses;

  gpio_reg_writer dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .gpio1_i  (gpio1_i),
    .gpio2_0_o(gpio2_0_o),
    .gpio2_1_o(gpio2_1_o),
    .gpio2_2_o(gpio2_2_o),
    .gpio2_3_o(gpio2_3_o),
    .regs_o   (regs_o),
    .wr_stb_o (wr_stb_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] flat_model();
    logic [511:0] f;
    f = '0;
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 8; r++)
        f[(b*8+r)*16 +: 16] = model[b][r];
    return f;
  endfunction

  task automatic clear_model();
    for (int b = 0; b < 4; b++)
      for (int r = 0; r < 8; r++)
        model[b][r] = 16'h0000;
    ack_m = 1'b0;
  endtask

  // Full software protocol: fields with strobe low, then strobe high, then low.
  task automatic send(input logic [1:0] b, input logic [2:0] i, input logic [15:0] d,
                      input logic [9:0] rsv);
    gpio1_i = {1'b0, b, i, rsv, d};
    tick();
    gpio1_i[31] = 1'b1;
    ticks(3);                        // now just past edge N+2
    chk("wr_stb_before_n3", wr_stb_o, 4'b0000);
    tick();                          // edge N+3
    model[b][i] = d;
    ack_m = ~ack_m;
    chk("wr_stb_pulse", wr_stb_o, 4'b0001 << b);
    chk("regs_after_write", regs_o, flat_model());
    tick();
    chk("wr_stb_one_cycle", wr_stb_o, 4'b0000);
    gpio1_i[31] = 1'b0;
    ticks(4);
    chk("ack_bit", gpio2_0_o[31], ack_m);
  endtask

  initial begin
    clear_model();
    rst_i   = 1'b1;
    gpio1_i = 32'h0;

    // Reset state.
    ticks(2);
    chk("rst_regs", regs_o, '0);
    chk("rst_wr_stb", wr_stb_o, 4'b0000);
    chk("rst_gpio2_0", gpio2_0_o, 32'h0000_0000);
    chk("rst_gpio2_1", gpio2_1_o, 32'h2000_0000);
    chk("rst_gpio2_2", gpio2_2_o, 32'h4000_0000);
    chk("rst_gpio2_3", gpio2_3_o, 32'h6000_0000);
    rst_i = 1'b0;
    ticks(5);

    // Single write: bank 2 idx 5 = 0xBEEF, slice 21.
    send(2'd2, 3'd5, 16'hBEEF, 10'h000);
    chk("slice21", regs_o[21*16 +: 16], 16'hBEEF);

    // Readback latency on bank 1 after writing idx 2.
    send(2'd1, 3'd2, 16'h00C3, 10'h000);
    gpio1_i = {1'b0, 2'b01, 3'b000, 10'h0, 16'h0};
    ticks(4);
    gpio1_i = {1'b0, 2'b01, 3'b010, 10'h0, 16'h0};
    ticks(2);                        // sync2 index just became 2
    chk("rb1_old_idx", gpio2_1_o, {1'b0, 2'b01, 3'b000, 10'b0, 16'h0000});
    tick();
    chk("rb1_new_idx", gpio2_1_o, {1'b0, 2'b01, 3'b010, 10'b0, 16'h00C3});
    chk("rb2_idx2", gpio2_2_o, {1'b0, 2'b10, 3'b010, 10'b0, 16'h0000});

    // Reserved bits ignored.
    send(2'd1, 3'd3, 16'h0001, 10'h3FF);
    chk("rsv_ignored", regs_o[11*16 +: 16], 16'h0001);

    // Strobe held 100 cycles, data changed mid-hold: one write of 0x1234.
    gpio1_i = {1'b0, 2'd0, 3'd0, 10'h0, 16'h1234};
    tick();
    gpio1_i[31] = 1'b1;
    pulses = 0;
    for (int c = 0; c < 100; c++) begin
      if (c == 50) gpio1_i[15:0] = 16'h5678;
      tick();
      if (wr_stb_o != 4'b0000) pulses++;
    end
    model[0][0] = 16'h1234;
    ack_m = ~ack_m;
    chk("hold_one_pulse", pulses, 1);
    chk("hold_regs", regs_o, flat_model());
    gpio1_i[31] = 1'b0;
    ticks(4);
    chk("hold_ack", gpio2_0_o[31], ack_m);

    // Back-to-back writes, one per bank, idx 7.
    for (int b = 0; b < 4; b++) send(2'(b), 3'd7, 16'hA000 + 16'(b), 10'h000);
    chk("b2b_ack_ends_0", gpio2_3_o[31], 1'b0);
    gpio1_i = {1'b0, 2'd0, 3'd7, 10'h0, 16'h0};
    ticks(3);
    chk("rb0_idx7", gpio2_0_o, {1'b0, 2'b00, 3'b111, 10'b0, 16'hA000});
    chk("rb1_idx7", gpio2_1_o, {1'b0, 2'b01, 3'b111, 10'b0, 16'hA001});
    chk("rb2_idx7", gpio2_2_o, {1'b0, 2'b10, 3'b111, 10'b0, 16'hA002});
    chk("rb3_idx7", gpio2_3_o, {1'b0, 2'b11, 3'b111, 10'b0, 16'hA003});

    // One-cycle strobe pulse still produces a write.
    gpio1_i = {1'b0, 2'd2, 3'd0, 10'h0, 16'h0055};
    tick();
    gpio1_i[31] = 1'b1;
    tick();                          // edge N
    gpio1_i[31] = 1'b0;
    ticks(2);
    chk("pulse_pre", wr_stb_o, 4'b0000);
    tick();                          // edge N+3
    model[2][0] = 16'h0055;
    ack_m = ~ack_m;
    chk("pulse_stb", wr_stb_o, 4'b0100);
    chk("pulse_regs", regs_o, flat_model());
    ticks(4);

    // Reset while in WRITE aborts; held strobe must not write after release.
    gpio1_i = {1'b0, 2'd3, 3'd0, 10'h0, 16'hFFFF};
    tick();
    gpio1_i[31] = 1'b1;
    ticks(3);                        // FSM in WRITE
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    clear_model();
    chk("abort_stb", wr_stb_o, 4'b0000);
    chk("abort_regs", regs_o, '0);
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (wr_stb_o != 4'b0000) pulses++;
    end
    chk("abort_no_rewrite", pulses, 0);
    chk("abort_regs_held", regs_o, '0);
    gpio1_i[31] = 1'b0;
    ticks(4);
    send(2'd3, 3'd0, 16'hFFFF, 10'h000);
    chk("retoggle_slice24", regs_o[24*16 +: 16], 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gpio_reg_writer.md
GPIO_REG_WRITER -- requirements
Module: gpio_reg_writer

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of register banks (fixed 4 in this release).
REQ-002 SHALL have parameter REGS_PER_BANK, default 8, number of registers per bank.
REQ-003 SHALL have parameter REG_W, default 16, width of each register.
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port gpio1_i  in  32  PS command word, asynchronous to clk_i: [31] write strobe, [30:29] bank, [28:26] reg index, [25:16] reserved, [15:0] data.
REQ-007 SHALL have port gpio2_0_o .. gpio2_3_o  out  32 each  per-bank readback word feeding the readback mux.
REQ-008 SHALL have port regs_o  out  NUM_BANKS*REGS_PER_BANK*REG_W  flat register contents; bank b, reg r occupies bits starting at (b*REGS_PER_BANK+r)*REG_W.
REQ-009 SHALL have port wr_stb_o  out  NUM_BANKS  one-cycle pulse on the bank just written.

Function
REQ-010 SHALL pass all 32 bits of gpio1_i through a 2-flop synchronizer; all decoding uses the second stage (sync2).
REQ-011 SHALL implement FSM IDLE, WRITE, WAIT_LOW; reset state IDLE.
REQ-012 IDLE: on sync2[31]=1 with previous-cycle sync2[31]=0, SHALL latch bank, index and data from that same sync2 sample and go to WRITE.
REQ-013 WRITE: SHALL write latched data to the latched bank/index, assert wr_stb_o[bank] for exactly the next cycle, toggle the ack bit, go to WAIT_LOW.
REQ-014 WAIT_LOW: SHALL stay until sync2[31]=0, then go to IDLE; a strobe held high SHALL produce exactly one write.
REQ-015 Latency: strobe first sampled high at edge N -> capture at edge N+2 -> register, ack and wr_stb_o updated at edge N+3.
REQ-016 Strobe dropping during WRITE SHALL NOT abort the write; WAIT_LOW then exits on the next cycle.
REQ-017 Strobe pulse of at least 1 clk_i period at sync input SHALL be detected; field changes while not in IDLE SHALL be ignored.
REQ-018 Reserved bits [25:16] SHALL be ignored; all 4x8 addresses SHALL be writable; no other register SHALL change on a write.
REQ-019 Software protocol (decided): write fields with strobe=0, then identical fields with strobe=1, then strobe=0; this guarantees field stability at capture.
REQ-020 gpio2_k_o SHALL be registered (1-cycle latency from sync2): [31] ack toggle, [30:29] constant k, [28:26] sync2 index, [25:16] zero, [15:0] bank k register at sync2 index.
REQ-021 regs_o SHALL be driven directly from the register array flops.

Reset
REQ-022 On rst_i=1 at a clock edge: all registers 0, ack 0, wr_stb_o 0, FSM IDLE, synchronizer and edge-detect flops 0, gpio2_k_o = {1'b0, k[1:0], 29'b0}.
REQ-023 Reset asserted in WRITE or WAIT_LOW SHALL abort without writing; after release a still-high strobe SHALL NOT trigger a write until it goes low and high again.

Structure
REQ-024 Package gpio_reg_pkg SHALL hold field bit positions, NUM_BANKS, REGS_PER_BANK, REG_W and the FSM state encoding.
REQ-025 Sub-module gpio_sync (parameterized-width 2-flop synchronizer, synchronous reset) SHALL be instantiated once for gpio1_i.

Verification
REQ-026 Reset, then write bank 2 idx 5 data 0xBEEF via REQ-019 protocol -> regs_o slice 21 = 0xBEEF at edge N+3, wr_stb_o=4'b0100 one cycle, ack=1, all other slices 0.
REQ-027 Strobe held high 100 cycles with data 0x1234 to bank 0 idx 0 -> exactly one wr_stb_o pulse; a data change to 0x5678 mid-hold leaves 0x1234.
REQ-028 Four back-to-back writes, one per bank, idx 7, data 0xA000+bank -> all four values present, ack toggles 4 times (ends 0), gpio2_k_o[15:0] shows 0xA00k when sync2 index=7.
REQ-029 Reserved bits set to 0x3FF on a write of 0x0001 to bank 1 idx 3 -> stored value 0x0001.
REQ-030 rst_i pulsed at cycle N+2 of a write of 0xFFFF to bank 3 idx 0 -> register stays 0, no wr_stb_o; strobe still high after release -> no write until low-high retoggle.
REQ-031 Bank 1 idx 2 = 0x00C3; set sync2 index 2 -> one cycle later gpio2_1_o = {ack,2'b01,3'b010,10'b0,16'h00C3}.
